// File: rtl/bean2_ctrl_pkg.sv
// Shared encodings for the BEAN-2 control path: opcodes, select encodings,
// pipeline control-word structs and the funct3-to-ALU mapping.
package bean2_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } reg_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_e;

  typedef struct packed {
    alu_sel_e   alu_sel;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       dmem_we;
    logic [2:0] dmem_sel;
    logic       reg_we;
    reg_sel_e   reg_sel;
  } ctrl_word_t;

  typedef struct packed {
    logic       dmem_we;
    logic [2:0] dmem_sel;
    logic       reg_we;
    reg_sel_e   reg_sel;
  } mem_word_t;

  typedef struct packed {
    logic     reg_we;
    reg_sel_e reg_sel;
  } wb_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = ctrl_word_t'('0);
  localparam mem_word_t  MEM_BUBBLE  = mem_word_t'('0);
  localparam wb_word_t   WB_BUBBLE   = wb_word_t'('0);

  // alt_sub only applies to register-register ops; alt_sra applies to both.
  function automatic alu_sel_e alu_decode(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       is_reg_op);
    alu_sel_e sel;
    case (funct3)
      3'b000:  sel = (alt && is_reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational D-stage decoder: opcode/funct3/funct7 to control word plus
// the immediate format and source-register usage needed in D.
module control_decoder
  import bean2_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_word_t ctrl,
  output imm_sel_e   imm_sel,
  output logic [1:0] reg_rd
);

  // Only funct7[5] distinguishes RV32I operations.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_sel = IMM_I;
    reg_rd  = 2'b00;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_sel = alu_decode(funct3, funct7[5], 1'b1);
        ctrl.reg_we  = 1'b1;
        ctrl.reg_sel = WB_ALU;
        reg_rd       = 2'b11;
      end
      OPC_OP_IMM: begin
        ctrl.alu_sel = alu_decode(funct3, funct7[5], 1'b0);
        ctrl.rs2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.reg_sel = WB_ALU;
        imm_sel      = IMM_I;
        reg_rd       = 2'b01;
      end
      OPC_LOAD: begin
        ctrl.alu_sel  = ALU_ADD;
        ctrl.rs2_sel  = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.reg_sel  = WB_MEM;
        ctrl.dmem_sel = funct3;
        imm_sel       = IMM_I;
        reg_rd        = 2'b01;
      end
      OPC_STORE: begin
        ctrl.alu_sel  = ALU_ADD;
        ctrl.rs2_sel  = 1'b1;
        ctrl.dmem_we  = 1'b1;
        ctrl.dmem_sel = funct3;
        imm_sel       = IMM_S;
        reg_rd        = 2'b11;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        imm_sel     = IMM_B;
        reg_rd      = 2'b11;
      end
      OPC_JAL: begin
        ctrl.jal     = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.reg_sel = WB_PC4;
        imm_sel      = IMM_J;
        reg_rd       = 2'b00;
      end
      OPC_JALR: begin
        ctrl.alu_sel = ALU_ADD;
        ctrl.rs2_sel = 1'b1;
        ctrl.jalr    = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.reg_sel = WB_PC4;
        imm_sel      = IMM_I;
        reg_rd       = 2'b01;
      end
      OPC_LUI: begin
        ctrl.alu_sel = ALU_PASS_B;
        ctrl.rs2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm_sel      = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.alu_sel = ALU_ADD;
        ctrl.rs1_sel = 1'b1;
        ctrl.rs2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm_sel      = IMM_U;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_logic_unit.sv
// BEAN-2 control unit: D-stage decode plus E/M/WB control pipeline registers
// with reset > flush > stall > load priority, and next-PC select.
module control_logic_unit
  import bean2_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       jump,
  input  logic       stall_E,
  input  logic       stall_M,
  input  logic       stall_WB,
  input  logic       flush_E,
  input  logic       flush_M,
  input  logic       flush_WB,
  output logic [2:0] imm_SEL,
  output logic [1:0] reg_RD,
  output logic       reg_WE_D_out,
  output logic [3:0] ALU_SEL,
  output logic       rs1_SEL,
  output logic       rs2_SEL,
  output logic [1:0] pc_SEL,
  output logic       dmem_WE,
  output logic [2:0] dmem_SEL,
  output logic       reg_WE,
  output logic [1:0] reg_SEL
);

  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_e;
  mem_word_t  ctrl_m;
  wb_word_t   ctrl_wb;
  imm_sel_e   imm_sel_d;
  pc_sel_e    pc_sel;

  control_decoder u_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (ctrl_d),
    .imm_sel (imm_sel_d),
    .reg_rd  (reg_RD)
  );

  always_ff @(posedge clk) begin
    if (reset)        ctrl_e <= CTRL_BUBBLE;
    else if (flush_E) ctrl_e <= CTRL_BUBBLE;
    else if (!stall_E) ctrl_e <= ctrl_d;
  end

  // M loads from E even while E stalls; the hazard unit flushes M if needed.
  always_ff @(posedge clk) begin
    if (reset)        ctrl_m <= MEM_BUBBLE;
    else if (flush_M) ctrl_m <= MEM_BUBBLE;
    else if (!stall_M) begin
      ctrl_m.dmem_we  <= ctrl_e.dmem_we;
      ctrl_m.dmem_sel <= ctrl_e.dmem_sel;
      ctrl_m.reg_we   <= ctrl_e.reg_we;
      ctrl_m.reg_sel  <= ctrl_e.reg_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         ctrl_wb <= WB_BUBBLE;
    else if (flush_WB) ctrl_wb <= WB_BUBBLE;
    else if (!stall_WB) begin
      ctrl_wb.reg_we  <= ctrl_m.reg_we;
      ctrl_wb.reg_sel <= ctrl_m.reg_sel;
    end
  end

  always_comb begin
    pc_sel = PC_PLUS4;
    if (ctrl_e.jalr)
      pc_sel = PC_JALR;
    else if (ctrl_e.jal || (ctrl_e.branch && jump))
      pc_sel = PC_TARGET;
  end

  assign imm_SEL      = imm_sel_d;
  assign reg_WE_D_out = ctrl_d.reg_we;
  assign ALU_SEL      = ctrl_e.alu_sel;
  assign rs1_SEL      = ctrl_e.rs1_sel;
  assign rs2_SEL      = ctrl_e.rs2_sel;
  assign pc_SEL       = pc_sel;
  assign dmem_WE      = ctrl_m.dmem_we;
  assign dmem_SEL     = ctrl_m.dmem_sel;
  assign reg_WE       = ctrl_wb.reg_we;
  assign reg_SEL      = ctrl_wb.reg_sel;

endmodule

// File: tb/tb_control_logic_unit.sv
// Self-checking bench for control_logic_unit: directed scenarios then random
// traffic, checked against an instruction-level pipeline model.
module tb_control_logic_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       jump;
  logic       stall_E, stall_M, stall_WB;
  logic       flush_E, flush_M, flush_WB;
  logic [2:0] imm_SEL;
  logic [1:0] reg_RD;
  logic       reg_WE_D_out;
  logic [3:0] ALU_SEL;
  logic       rs1_SEL, rs2_SEL;
  logic [1:0] pc_SEL;
  logic       dmem_WE;
  logic [2:0] dmem_SEL;
  logic       reg_WE;
  logic [1:0] reg_SEL;

  always #5 clk = ~clk;

  control_logic_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .jump(jump), .stall_E(stall_E), .stall_M(stall_M), .stall_WB(stall_WB),
    .flush_E(flush_E), .flush_M(flush_M), .flush_WB(flush_WB),
    .imm_SEL(imm_SEL), .reg_RD(reg_RD), .reg_WE_D_out(reg_WE_D_out),
    .ALU_SEL(ALU_SEL), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .pc_SEL(pc_SEL),
    .dmem_WE(dmem_WE), .dmem_SEL(dmem_SEL), .reg_WE(reg_WE), .reg_SEL(reg_SEL)
  );

  // The model tracks which instruction occupies each stage, not control bits.
  typedef struct {
    bit         valid;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
  } ins_t;

  typedef struct {
    int alu; int rs1s; int rs2s; int imm; int rd; int we; int rsel;
    int dwe; int dsel; int br; int jal; int jalr;
  } exp_t;

  int tests = 0;
  int fails = 0;
  ins_t e_i, m_i, wb_i;
  ins_t bub;

  function automatic int alu_of(logic [2:0] f3, logic alt, bit reg_op);
    int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int r;
    r = base[f3];
    if (f3 == 3'd0 && alt && reg_op) r = 1;
    if (f3 == 3'd5 && alt) r = 7;
    return r;
  endfunction

  function automatic exp_t spec_of(ins_t i);
    exp_t x = '{default: 0};
    if (!i.valid) return x;
    case (i.op)
      7'b0110011: begin x.alu = alu_of(i.f3, i.f7[5], 1'b1); x.we = 1; x.rd = 3; end
      7'b0010011: begin x.alu = alu_of(i.f3, i.f7[5], 1'b0); x.rs2s = 1; x.we = 1; x.rd = 1; end
      7'b0000011: begin x.rs2s = 1; x.we = 1; x.rsel = 1; x.dsel = int'(i.f3); x.rd = 1; end
      7'b0100011: begin x.rs2s = 1; x.imm = 1; x.dwe = 1; x.dsel = int'(i.f3); x.rd = 3; end
      7'b1100011: begin x.imm = 2; x.br = 1; x.rd = 3; end
      7'b1101111: begin x.imm = 4; x.jal = 1; x.we = 1; x.rsel = 2; end
      7'b1100111: begin x.rs2s = 1; x.jalr = 1; x.we = 1; x.rsel = 2; x.rd = 1; end
      7'b0110111: begin x.alu = 10; x.rs2s = 1; x.imm = 3; x.we = 1; end
      7'b0010111: begin x.rs1s = 1; x.rs2s = 1; x.imm = 3; x.we = 1; end
      default: ;
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t d, e, m, w;
    int pc;
    d = spec_of('{1'b1, opcode, funct3, funct7});
    e = spec_of(e_i);
    m = spec_of(m_i);
    w = spec_of(wb_i);
    pc = e.jalr ? 2 : ((e.jal || (e.br && jump)) ? 1 : 0);
    chk("imm_SEL", 32'(imm_SEL), d.imm);
    chk("reg_RD", 32'(reg_RD), d.rd);
    chk("reg_WE_D_out", 32'(reg_WE_D_out), d.we);
    chk("ALU_SEL", 32'(ALU_SEL), e.alu);
    chk("rs1_SEL", 32'(rs1_SEL), e.rs1s);
    chk("rs2_SEL", 32'(rs2_SEL), e.rs2s);
    chk("pc_SEL", 32'(pc_SEL), pc);
    chk("dmem_WE", 32'(dmem_WE), m.dwe);
    chk("dmem_SEL", 32'(dmem_SEL), m.dsel);
    chk("reg_WE", 32'(reg_WE), w.we);
    chk("reg_SEL", 32'(reg_SEL), w.rsel);
  endtask

  task automatic tick();
    ins_t d;
    @(posedge clk);
    d = '{1'b1, opcode, funct3, funct7};
    if (reset) begin
      e_i = bub; m_i = bub; wb_i = bub;
    end else begin
      wb_i = flush_WB ? bub : (stall_WB ? wb_i : m_i);
      m_i  = flush_M  ? bub : (stall_M  ? m_i  : e_i);
      e_i  = flush_E  ? bub : (stall_E  ? e_i  : d);
    end
    #1;
    check_all();
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  initial begin
    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b0001111, 7'b1110011};
    bub = '{1'b0, 7'd0, 3'd0, 7'd0};
    e_i = bub; m_i = bub; wb_i = bub;
    jump = 0;
    stall_E = 0; stall_M = 0; stall_WB = 0;
    flush_E = 0; flush_M = 0; flush_WB = 0;

    // Reset with an OP instruction in D
    reset = 1;
    set_ins(7'b0110011, 3'b000, 7'b0000000);
    tick();
    tick();
    chk("reset_alu", 32'(ALU_SEL), 0);
    chk("reset_pc", 32'(pc_SEL), 0);
    chk("reset_reg_we", 32'(reg_WE), 0);
    chk("reset_dmem_we", 32'(dmem_WE), 0);
    reset = 0;

    // ADD then SUB
    set_ins(7'b0110011, 3'b000, 7'b0000000);
    tick();
    chk("add_alu", 32'(ALU_SEL), 0);
    set_ins(7'b0110011, 3'b000, 7'b0100000);
    tick();
    chk("sub_alu", 32'(ALU_SEL), 1);
    set_ins(7'b0000000, 3'b000, 7'b0000000);
    tick();
    chk("add_wb_we", 32'(reg_WE), 1);
    chk("add_wb_sel", 32'(reg_SEL), 0);

    // SW
    set_ins(7'b0100011, 3'b010, 7'b0000000);
    #1;
    chk("sw_imm", 32'(imm_SEL), 1);
    chk("sw_rd", 32'(reg_RD), 3);
    tick();
    set_ins(7'b0000000, 3'b000, 7'b0000000);
    tick();
    chk("sw_dmem_we", 32'(dmem_WE), 1);
    chk("sw_dmem_sel", 32'(dmem_SEL), 2);
    tick();
    chk("sw_wb_we", 32'(reg_WE), 0);

    // BEQ, JALR, JAL
    set_ins(7'b1100011, 3'b000, 7'b0000000);
    tick();
    jump = 1; #1;
    chk("beq_taken", 32'(pc_SEL), 1);
    jump = 0; #1;
    chk("beq_not_taken", 32'(pc_SEL), 0);
    set_ins(7'b1100111, 3'b000, 7'b0000000);
    tick();
    chk("jalr_pc", 32'(pc_SEL), 2);
    set_ins(7'b1101111, 3'b000, 7'b0000000);
    tick();
    chk("jal_pc", 32'(pc_SEL), 1);
    set_ins(7'b0000000, 3'b000, 7'b0000000);
    tick();
    tick();
    chk("jal_wb_we", 32'(reg_WE), 1);
    chk("jal_wb_sel", 32'(reg_SEL), 2);

    // LW held by stall_E, then flush beats stall
    set_ins(7'b0000011, 3'b010, 7'b0000000);
    tick();
    set_ins(7'b0110111, 3'b000, 7'b0000000);
    stall_E = 1;
    tick();
    chk("stall_alu", 32'(ALU_SEL), 0);
    chk("stall_rs2", 32'(rs2_SEL), 1);
    flush_E = 1;
    tick();
    chk("flush_alu", 32'(ALU_SEL), 0);
    chk("flush_rs2", 32'(rs2_SEL), 0);
    stall_E = 0; flush_E = 0;
    tick();
    tick();
    chk("flush_m_we", 32'(dmem_WE), 0);

    // Illegal opcode
    set_ins(7'b1111111, 3'b111, 7'b1111111);
    #1;
    chk("illegal_we_d", 32'(reg_WE_D_out), 0);
    chk("illegal_rd", 32'(reg_RD), 0);
    tick(); tick(); tick();
    chk("illegal_m_we", 32'(dmem_WE), 0);
    chk("illegal_wb_we", 32'(reg_WE), 0);

    // Mid-stream reset
    set_ins(7'b0100011, 3'b001, 7'b0000000);
    tick();
    set_ins(7'b0010111, 3'b000, 7'b0000000);
    tick();
    reset = 1;
    tick();
    chk("midreset_rs1", 32'(rs1_SEL), 0);
    chk("midreset_dmem", 32'(dmem_WE), 0);
    reset = 0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) opcode = 7'($urandom);
      else opcode = ops[$urandom_range(0, 10)];
      funct3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0: funct7 = 7'b0000000;
        1: funct7 = 7'b0100000;
        default: funct7 = 7'($urandom);
      endcase
      jump     = 1'($urandom);
      stall_E  = ($urandom_range(0, 5) == 0);
      stall_M  = ($urandom_range(0, 5) == 0);
      stall_WB = ($urandom_range(0, 5) == 0);
      flush_E  = ($urandom_range(0, 7) == 0);
      flush_M  = ($urandom_range(0, 7) == 0);
      flush_WB = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_logic_unit.md
# control_logic_unit

Control unit of the BEAN-2 five-stage pipelined RV32I core. It decodes the instruction fields that the datapath presents in the Decode (D) stage. It then carries the resulting control word through Execute (E), Memory (M) and Writeback (WB) pipeline registers, which obey the stall and flush requests from the hazard unit. It also drives the D-stage register-use information that the hazard unit needs.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  D-stage instr[6:0].
- funct3  in  3  D-stage instr[14:12].
- funct7  in  7  D-stage instr[31:25].
- jump  in  1  E-stage branch-comparator result (1 = condition true for the E-stage funct3).
- stall_E, stall_M, stall_WB  in  1 each  hold the corresponding pipeline register.
- flush_E, flush_M, flush_WB  in  1 each  load a bubble into the corresponding register.
- imm_SEL  out  3  D-stage immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
- reg_RD  out  2  D-stage source use: bit0 = reads rs1, bit1 = reads rs2.
- reg_WE_D_out  out  1  D-stage decoded register-write enable, used by the hazard unit.
- ALU_SEL  out  4  E-stage ALU operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- rs1_SEL  out  1  E-stage ALU A source: 0 rs1 data, 1 PC.
- rs2_SEL  out  1  E-stage ALU B source: 0 rs2 data, 1 immediate.
- pc_SEL  out  2  next-PC source: 0 PC+4, 1 PC_E+imm (branch taken / JAL), 2 ALU result with bit0 cleared (JALR).
- dmem_WE  out  1  M-stage data-memory write enable.
- dmem_SEL  out  3  M-stage access size; equals funct3 of the load/store (000 B, 001 H, 010 W, 100 BU, 101 HU).
- reg_WE  out  1  WB-stage register-file write enable.
- reg_SEL  out  2  WB-stage writeback source: 0 ALU, 1 memory, 2 PC+4.

## Operation
- The decode is combinational from opcode, funct3 and funct7. Per-opcode decode:
  - OP (0110011): ALU from funct3 and funct7[5]; rs2_SEL=0; reg_WE=1; reg_SEL=0; reg_RD=11.
  - OP-IMM (0010011): same as OP, except funct7[5] selects SRA only when funct3=101; SUB is never produced; rs2_SEL=1; imm I; reg_RD=01.
  - LOAD (0000011): ADD; rs2_SEL=1; imm I; reg_WE=1; reg_SEL=1; dmem_SEL=funct3; reg_RD=01.
  - STORE (0100011): ADD; rs2_SEL=1; imm S; dmem_WE=1; dmem_SEL=funct3; reg_RD=11.
  - BRANCH (1100011): imm B; branch flag set; reg_RD=11; no writes.
  - JAL (1101111): imm J; jal flag set; reg_WE=1; reg_SEL=2; reg_RD=00.
  - JALR (1100111): ADD; rs2_SEL=1; imm I; jalr flag set; reg_WE=1; reg_SEL=2; reg_RD=01.
  - LUI (0110111): PASS_B; rs2_SEL=1; imm U; reg_WE=1; reg_RD=00.
  - AUIPC (0010111): ADD; rs1_SEL=1; rs2_SEL=1; imm U; reg_WE=1; reg_RD=00.
  - Any other opcode (FENCE, SYSTEM, illegal): all-zero control word, i.e. a bubble.
- The E register holds ALU_SEL, rs1_SEL, rs2_SEL, the branch/jal/jalr flags, dmem_WE, dmem_SEL, reg_WE and reg_SEL.
- The M register holds dmem_WE, dmem_SEL, reg_WE and reg_SEL.
- The WB register holds reg_WE and reg_SEL.
- pc_SEL is combinational from E-register state:
  - 2 if jalr;
  - else 1 if jal, or if branch and jump;
  - else 0.
- Register update priority, for each stage: reset > flush > stall > normal load.
  - Bubble = all-zero control word (no writes, pc_SEL 0).
  - Stall holds the current contents.
- D-stage outputs (imm_SEL, reg_RD, reg_WE_D_out) are purely combinational and unaffected by stall/flush.

## Timing
- Decode to E: an instruction in D at edge n drives its E outputs during cycle n+1, its M outputs during n+2 and its WB outputs during n+3, provided there is no stall.
- pc_SEL reacts combinationally to jump within the same cycle.
- Reset:
  - E, M and WB registers clear on the first rising edge with reset=1.
  - After that edge, ALU_SEL=0, rs1_SEL=0, rs2_SEL=0, pc_SEL=0, dmem_WE=0, dmem_SEL=0, reg_WE=0 and reg_SEL=0.
  - Reset asserted mid-stream discards all in-flight control on that edge.
- Stall and flush asserted on the same stage at the same edge: the flush wins.
- Stalling E while M is not stalled propagates E's word into M and still holds E. The hazard unit is responsible for flushing M in that case.

## Structure
- Shared package `bean2_ctrl_pkg` holds:
  - opcode constants;
  - the ALU_SEL, imm_SEL, reg_SEL and pc_SEL encodings;
  - a packed control-word struct.
- One sub-module, `control_decoder`: a combinational opcode/funct to control-word decoder.
- The top level holds the three pipeline registers and the pc_SEL logic.

## Test plan
- Reset: hold reset 2 cycles with opcode 0110011 → all E/M/WB outputs 0 and pc_SEL 0.
- ADD then SUB (0110011, f3 000, f7 0000000 / 0100000) → ALU_SEL 0 then 1 one cycle later; reg_WE=1, reg_SEL=0 appears 3 cycles after decode.
- Store SW (0100011, f3 010) → imm_SEL=1 and reg_RD=11 in D; dmem_WE=1, dmem_SEL=010 in M; reg_WE stays 0 in WB.
- BEQ in E:
  - jump=1 → pc_SEL=1;
  - jump=0 → pc_SEL=0;
  - JALR in E → pc_SEL=2;
  - JAL with reg_SEL=2 → reg_WE=1 in WB.
- Stall/flush:
  - LW in D, stall_E=1 for one edge → E outputs unchanged.
  - flush_E=1 together with stall_E=1 → E becomes a bubble (ALU_SEL 0, dmem_WE 0, reg_WE 0).
- Illegal opcode 1111111 → reg_WE_D_out=0 and reg_RD=00; no writes reach M or WB.
